sec_access_arbiter: RTL and testbench
=====================================

// Module: sec_access_arbiter
// PURPOSE
//  Shares one combinational 32b-data/8b-check single-error-correcting core (syndrome + correction)
//  between two requesters: port 0 (host read/write path) and port 1 (background scrubber).
//  Arbitrates the requests, drives the core's data/check/enable inputs and classifies the syndrome.
//  Registers one result per transfer, applies response backpressure and keeps saturating error counters.
// PARAMETERS
//  CNT_W       16  width of each error counter
//  FIXED_PRIO  0   0 = round-robin between ports; 1 = port 0 always wins
// PORTS
//  clk            in   1    clock; all state updates on the rising edge
//  rst            in   1    synchronous reset, active-high
//  req_valid      in   2    request valid, one bit per port
//  req_ready      out  2    request accepted this cycle, one bit per port
//  req_mode       in   2    per port: 0 = encode (generate check bits), 1 = decode (check/correct)
//  req_data       in   64   per port data; port p uses bits [32p+31:32p]
//  req_check      in   16   per port stored check bits; port p uses bits [8p+7:8p]; ignored for encode
//  resp_valid     out  1    result register holds a result
//  resp_ready     in   1    consumer accepts the result
//  resp_port      out  1    port that issued the result
//  resp_data      out  32   corrected data, or raw data for encode and uncorrectable results
//  resp_check     out  8    generated or corrected check bits
//  resp_status    out  2    00 clean/encoded, 01 data bit corrected, 10 check bit corrected, 11 uncorrectable
//  cnt_clear      in   1    synchronous clear of both counters
//  cnt_corr       out  CNT_W  count of status 01 and 10 results, saturating
//  cnt_unc        out  CNT_W  count of status 11 results, saturating
//  dp_id          out  32   core data input; bit i = core data bit i
//  dp_ic          out  8    core check input; bit i = core check bit i
//  dp_r           out  1    core check enable: 0 for encode, 1 for decode
//  dp_od          in   32   core corrected data output
//  dp_s           in   8    core syndrome output
// BEHAVIOUR
//  Reset: resp_valid=0, resp_port=0, resp_data=0, resp_check=0, resp_status=0, cnt_*=0, rr_ptr=0, state EMPTY.
//  FSM with two states:
//   - EMPTY: the result register is free.
//   - FULL: resp_valid=1.
//  can_accept = (state==EMPTY) | resp_ready.
//  Grant, combinational: no grant unless can_accept.
//   - One valid port: that port is granted.
//   - Both valid: with FIXED_PRIO=1, port 0 is granted; otherwise port rr_ptr is granted.
//   - req_ready = one-hot grant vector, or 0. At most one grant per cycle.
//   - req_ready never depends on req_ready; it may depend on req_valid.
//  rr_ptr <= ~granted_port on every grant. Unchanged when there is no grant.
//  Core drive (combinational mux of the granted port, or port 0 when idle):
//   - dp_id = data, dp_ic = check.
//   - dp_r = mode.
//   - Encode forces dp_ic = 0.
//  Classification, on a decode grant only:
//   - dp_s==0 -> status 00; data=dp_id, check=dp_ic.
//   - popcount(dp_s)==1 -> status 10; data=dp_id, check=dp_ic^dp_s.
//   - dp_od!=dp_id -> status 01; data=dp_od, check=dp_ic.
//   - otherwise -> status 11; data=dp_id, check=dp_ic (raw).
//  Encode grant: status 00, data=dp_id, check=dp_s.
//  Latency: exactly 1 cycle; the result is visible the cycle after the grant.
//  Transitions:
//   - EMPTY + grant -> FULL.
//   - FULL + resp_ready + grant -> FULL, loading the new result (back-to-back, 1 result/cycle).
//   - FULL + resp_ready + no grant -> EMPTY.
//   - FULL + !resp_ready -> FULL; outputs stable, no grants.
//  Counters:
//   - Update on result capture, not on consumption.
//   - Saturate at all-ones.
//   - cnt_clear beats a same-cycle increment; that event is not counted.
//  Reset mid-transfer: the pending result is discarded; resp_valid=0 the following cycle; no counter update.
// TESTING
//  1 Encode: p0 encode, data=32'h00000001 -> next cycle resp_check=8'h51, status 00, resp_port 0.
//  2 Decode, data-bit error: p1 decode, data=0, check=8'h51 -> resp_data=32'h00000001, status 01, cnt_corr=1.
//  3 Decode, check-bit error: data=0, check=8'h01 -> resp_data=0, resp_check=8'h00, status 10.
//  4 Decode, double error: data=32'h00000003, check=0 -> status 11, raw data returned, cnt_unc=1.
//  5 Round-robin: both ports valid continuously with resp_ready=1 -> grants alternate 0,1,0,1;
//    with FIXED_PRIO=1, always 0.
//  6 Backpressure: resp_ready=0 for 3 cycles -> outputs stable, req_ready=0.
//    Counter saturation: CNT_W=2, 5 corrected results -> cnt_corr stays at 3.
//    cnt_clear during a capture -> counter 0.

Source files
------------

// File: rtl/sec_access_arbiter.sv
// rtl/sec_access_arbiter.sv - two-port arbiter around a shared SEC syndrome/correction core
// Classifies the core syndrome, registers one result per grant and keeps saturating error counters.
module sec_access_arbiter #(
  parameter int CNT_W      = 16,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [1:0]       i_req_valid,
  output logic [1:0]       o_req_ready,
  input  logic [1:0]       i_req_mode,
  input  logic [63:0]      i_req_data,
  input  logic [15:0]      i_req_check,
  output logic             o_resp_valid,
  input  logic             i_resp_ready,
  output logic             o_resp_port,
  output logic [31:0]      o_resp_data,
  output logic [7:0]       o_resp_check,
  output logic [1:0]       o_resp_status,
  input  logic             i_cnt_clear,
  output logic [CNT_W-1:0] o_cnt_corr,
  output logic [CNT_W-1:0] o_cnt_unc,
  output logic [31:0]      o_dp_id,
  output logic [7:0]       o_dp_ic,
  output logic             o_dp_r,
  input  logic [31:0]      i_dp_od,
  input  logic [7:0]       i_dp_s
);

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t           r_state;
  logic             r_rr_ptr;
  logic             r_resp_port;
  logic [31:0]      r_resp_data;
  logic [7:0]       r_resp_check;
  logic [1:0]       r_resp_status;
  logic [CNT_W-1:0] r_cnt_corr;
  logic [CNT_W-1:0] r_cnt_unc;

  logic        w_can_accept;
  logic [1:0]  w_grant;
  logic        w_any;
  logic        w_sel;
  logic        w_mode;
  logic        w_s_one_hot;
  logic [31:0] w_res_data;
  logic [7:0]  w_res_check;
  logic [1:0]  w_res_status;

  assign w_can_accept = (r_state == S_EMPTY) | i_resp_ready;

  always_comb begin
    w_grant = 2'b00;
    if (w_can_accept) begin
      case (i_req_valid)
        2'b01:   w_grant = 2'b01;
        2'b10:   w_grant = 2'b10;
        2'b11:   w_grant = (FIXED_PRIO || !r_rr_ptr) ? 2'b01 : 2'b10;
        default: w_grant = 2'b00;
      endcase
    end
  end

  assign w_any       = |w_grant;
  assign w_sel       = w_grant[1];
  assign o_req_ready = w_grant;

  // Idle cycles present port 0 to the core so its inputs never float.
  assign w_mode  = i_req_mode[w_sel];
  assign o_dp_id = w_sel ? i_req_data[63:32] : i_req_data[31:0];
  assign o_dp_ic = !w_mode ? 8'h00 : (w_sel ? i_req_check[15:8] : i_req_check[7:0]);
  assign o_dp_r  = w_mode;

  assign w_s_one_hot = (i_dp_s != 8'h00) && ((i_dp_s & (i_dp_s - 8'h01)) == 8'h00);

  always_comb begin
    w_res_status = 2'b00;
    w_res_data   = o_dp_id;
    w_res_check  = o_dp_ic;
    if (!w_mode) begin
      w_res_check = i_dp_s;
    end else if (i_dp_s == 8'h00) begin
      w_res_status = 2'b00;
    end else if (w_s_one_hot) begin
      w_res_status = 2'b10;
      w_res_check  = o_dp_ic ^ i_dp_s;
    end else if (i_dp_od != o_dp_id) begin
      w_res_status = 2'b01;
      w_res_data   = i_dp_od;
    end else begin
      w_res_status = 2'b11;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_EMPTY;
      r_rr_ptr      <= 1'b0;
      r_resp_port   <= 1'b0;
      r_resp_data   <= '0;
      r_resp_check  <= '0;
      r_resp_status <= '0;
      r_cnt_corr    <= '0;
      r_cnt_unc     <= '0;
    end else begin
      if (w_any) begin
        r_state       <= S_FULL;
        r_rr_ptr      <= ~w_sel;
        r_resp_port   <= w_sel;
        r_resp_data   <= w_res_data;
        r_resp_check  <= w_res_check;
        r_resp_status <= w_res_status;
      end else if (r_state == S_FULL && i_resp_ready) begin
        r_state <= S_EMPTY;
      end
      // A clear wins over an increment landing in the same cycle.
      if (i_cnt_clear) begin
        r_cnt_corr <= '0;
        r_cnt_unc  <= '0;
      end else if (w_any) begin
        if ((w_res_status == 2'b01 || w_res_status == 2'b10) && !(&r_cnt_corr))
          r_cnt_corr <= r_cnt_corr + 1'b1;
        if (w_res_status == 2'b11 && !(&r_cnt_unc))
          r_cnt_unc <= r_cnt_unc + 1'b1;
      end
    end
  end

  assign o_resp_valid  = (r_state == S_FULL);
  assign o_resp_port   = r_resp_port;
  assign o_resp_data   = r_resp_data;
  assign o_resp_check  = r_resp_check;
  assign o_resp_status = r_resp_status;
  assign o_cnt_corr    = r_cnt_corr;
  assign o_cnt_unc     = r_cnt_unc;

endmodule

// File: tb/tb_sec_access_arbiter.sv
// tb/tb_sec_access_arbiter.sv - scoreboard bench for sec_access_arbiter with a behavioural SEC core
// Column i of the core's H matrix is the i-th weight-3 byte counting up from 8'h51.
module tb_sec_access_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_mode = '0;
  logic [63:0] req_data = '0;
  logic [15:0] req_check = '0;
  logic        resp_ready = 1'b1;
  logic        cnt_clear = 1'b0;

  logic [1:0]  m_req_ready;
  logic        m_resp_valid, m_resp_port, m_dp_r;
  logic [31:0] m_resp_data, m_dp_id, m_dp_od;
  logic [7:0]  m_resp_check, m_dp_ic, m_dp_s;
  logic [1:0]  m_resp_status;
  logic [15:0] m_cnt_corr, m_cnt_unc;

  logic [1:0]  f_req_ready;
  logic        f_resp_valid, f_resp_port, f_dp_r;
  logic [31:0] f_resp_data, f_dp_id, f_dp_od;
  logic [7:0]  f_resp_check, f_dp_ic, f_dp_s;
  logic [1:0]  f_resp_status;
  logic [1:0]  f_cnt_corr, f_cnt_unc;

  always #5 clk = ~clk;

  sec_access_arbiter #(.CNT_W(16), .FIXED_PRIO(1'b0)) u_main (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(m_req_ready),
    .i_req_mode(req_mode), .i_req_data(req_data), .i_req_check(req_check),
    .o_resp_valid(m_resp_valid), .i_resp_ready(resp_ready), .o_resp_port(m_resp_port),
    .o_resp_data(m_resp_data), .o_resp_check(m_resp_check), .o_resp_status(m_resp_status),
    .i_cnt_clear(cnt_clear), .o_cnt_corr(m_cnt_corr), .o_cnt_unc(m_cnt_unc),
    .o_dp_id(m_dp_id), .o_dp_ic(m_dp_ic), .o_dp_r(m_dp_r), .i_dp_od(m_dp_od), .i_dp_s(m_dp_s)
  );

  sec_access_arbiter #(.CNT_W(2), .FIXED_PRIO(1'b1)) u_fix (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(f_req_ready),
    .i_req_mode(req_mode), .i_req_data(req_data), .i_req_check(req_check),
    .o_resp_valid(f_resp_valid), .i_resp_ready(resp_ready), .o_resp_port(f_resp_port),
    .o_resp_data(f_resp_data), .o_resp_check(f_resp_check), .o_resp_status(f_resp_status),
    .i_cnt_clear(cnt_clear), .o_cnt_corr(f_cnt_corr), .o_cnt_unc(f_cnt_unc),
    .o_dp_id(f_dp_id), .o_dp_ic(f_dp_ic), .o_dp_r(f_dp_r), .i_dp_od(f_dp_od), .i_dp_s(f_dp_s)
  );

  function automatic logic [7:0] col(input int idx);
    int k = 0;
    logic [7:0] b = 8'h51;
    for (int n = 0; n < 256; n++) begin
      if ($countones(b) == 3) begin
        if (k == idx) return b;
        k++;
      end
      b = b + 8'h01;
    end
    return 8'h00;
  endfunction

  function automatic logic [7:0] core_syn(input logic [31:0] id, input logic [7:0] ic);
    logic [7:0] s = ic;
    for (int i = 0; i < 32; i++) if (id[i]) s = s ^ col(i);
    return s;
  endfunction

  function automatic logic [31:0] core_fix(input logic [31:0] id, input logic [7:0] s);
    logic [31:0] d = id;
    for (int i = 0; i < 32; i++) if (col(i) == s) d[i] = ~d[i];
    return d;
  endfunction

  assign m_dp_s  = core_syn(m_dp_id, m_dp_ic);
  assign m_dp_od = core_fix(m_dp_id, m_dp_s);
  assign f_dp_s  = core_syn(f_dp_id, f_dp_ic);
  assign f_dp_od = core_fix(f_dp_id, f_dp_s);

  typedef struct {
    logic        port;
    logic [31:0] data;
    logic [7:0]  check;
    logic [1:0]  status;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every result the main DUT hands over is checked against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && m_resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_result", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_port", {63'd0, m_resp_port}, {63'd0, e.port});
        chk("resp_data", {32'd0, m_resp_data}, {32'd0, e.data});
        chk("resp_check", {56'd0, m_resp_check}, {56'd0, e.check});
        chk("resp_status", {62'd0, m_resp_status}, {62'd0, e.status});
      end
    end
  end

  task automatic drive(input int p, input logic mode, input logic [31:0] d, input logic [7:0] c);
    req_valid[p]          = 1'b1;
    req_mode[p]           = mode;
    req_data[p*32 +: 32]  = d;
    req_check[p*8 +: 8]   = c;
  endtask

  task automatic issue(input int p, input logic mode, input logic [31:0] d, input logic [7:0] c,
                       input logic [31:0] ed, input logic [7:0] ec, input logic [1:0] es);
    bit got = 0;
    req_valid = 2'b00;
    drive(p, mode, d, c);
    for (int cyc = 0; cyc < 20 && !got; cyc++) begin
      @(negedge clk);
      if (m_req_ready[p]) begin
        got = 1;
        sb.push_back('{port: p[0], data: ed, check: ec, status: es});
      end
      @(posedge clk);
      #1;
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL grant_timeout: port %0d never granted", p);
    end
    req_valid = 2'b00;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_resp_valid", {63'd0, m_resp_valid}, 64'd0);
    chk("rst_resp_data", {32'd0, m_resp_data}, 64'd0);
    chk("rst_resp_check_status_port", {53'd0, m_resp_check, m_resp_status, m_resp_port}, 64'd0);
    chk("rst_cnt", {32'd0, m_cnt_corr, m_cnt_unc}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", {62'd0, m_req_ready}, 64'd0);
    chk("idle_resp_valid", {63'd0, m_resp_valid}, 64'd0);
    @(posedge clk);
    #1;

    issue(0, 1'b0, 32'h00000001, 8'h00, 32'h00000001, 8'h51, 2'b00);
    issue(1, 1'b1, 32'h00000000, 8'h51, 32'h00000001, 8'h51, 2'b01);
    @(negedge clk);
    chk("cnt_corr_1", {48'd0, m_cnt_corr}, 64'd1);
    @(posedge clk);
    #1;
    issue(1, 1'b1, 32'h00000000, 8'h01, 32'h00000000, 8'h00, 2'b10);
    issue(0, 1'b1, 32'h00000003, 8'h00, 32'h00000003, 8'h00, 2'b11);
    @(negedge clk);
    chk("cnt_corr_2", {48'd0, m_cnt_corr}, 64'd2);
    chk("cnt_unc_1", {48'd0, m_cnt_unc}, 64'd1);
    chk("fix_cnt_corr_2", {62'd0, f_cnt_corr}, 64'd2);
    chk("fix_cnt_unc_1", {62'd0, f_cnt_unc}, 64'd1);
    @(posedge clk);
    #1;
    issue(0, 1'b0, 32'h00000002, 8'h00, 32'h00000002, 8'h52, 2'b00);
    issue(0, 1'b1, 32'h00000001, 8'h51, 32'h00000001, 8'h51, 2'b00);
    for (int i = 0; i < 3; i++)
      issue(1, 1'b1, 32'h00000000, 8'h51, 32'h00000001, 8'h51, 2'b01);
    @(negedge clk);
    chk("cnt_corr_5", {48'd0, m_cnt_corr}, 64'd5);
    chk("fix_cnt_corr_sat", {62'd0, f_cnt_corr}, 64'd3);
    @(posedge clk);
    #1;

    // Last grant went to port 1, so the round-robin pointer now favours port 0.
    req_valid = 2'b00;
    drive(0, 1'b0, 32'h00000001, 8'h00);
    drive(1, 1'b0, 32'h00000000, 8'h00);
    for (int i = 0; i < 4; i++) begin
      logic [1:0] eg;
      eg = (i % 2 == 0) ? 2'b01 : 2'b10;
      @(negedge clk);
      chk("rr_grant", {62'd0, m_req_ready}, {62'd0, eg});
      chk("fix_prio_grant", {62'd0, f_req_ready}, 64'd1);
      if (m_req_ready == 2'b01) sb.push_back('{port: 1'b0, data: 32'h1, check: 8'h51, status: 2'b00});
      if (m_req_ready == 2'b10) sb.push_back('{port: 1'b1, data: 32'h0, check: 8'h00, status: 2'b00});
      @(posedge clk);
      #1;
    end
    req_valid = 2'b00;
    @(posedge clk);
    #1;

    resp_ready = 1'b0;
    issue(0, 1'b0, 32'h00000001, 8'h00, 32'h00000001, 8'h51, 2'b00);
    drive(1, 1'b1, 32'h00000000, 8'h01);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_req_ready", {62'd0, m_req_ready}, 64'd0);
      chk("bp_hold", {m_resp_valid, m_resp_port, m_resp_status, 20'd0, m_resp_check, m_resp_data},
          {1'b1, 1'b0, 2'b00, 20'd0, 8'h51, 32'h00000001});
      @(posedge clk);
      #1;
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_grant", {62'd0, m_req_ready}, 64'd2);
    if (m_req_ready == 2'b10) sb.push_back('{port: 1'b1, data: 32'h0, check: 8'h00, status: 2'b10});
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    @(negedge clk);
    chk("cnt_corr_6", {48'd0, m_cnt_corr}, 64'd6);
    @(posedge clk);
    #1;

    cnt_clear = 1'b1;
    drive(0, 1'b1, 32'h00000000, 8'h51);
    @(negedge clk);
    chk("clear_grant", {62'd0, m_req_ready}, 64'd1);
    if (m_req_ready == 2'b01) sb.push_back('{port: 1'b0, data: 32'h1, check: 8'h51, status: 2'b01});
    @(posedge clk);
    #1;
    cnt_clear = 1'b0;
    req_valid = 2'b00;
    @(negedge clk);
    chk("clear_cnt_main", {32'd0, m_cnt_corr, m_cnt_unc}, 64'd0);
    chk("clear_cnt_fix", {60'd0, f_cnt_corr, f_cnt_unc}, 64'd0);
    @(posedge clk);
    #1;

    drive(0, 1'b1, 32'h00000000, 8'h51);
    @(negedge clk);
    chk("rstmid_grant", {62'd0, m_req_ready}, 64'd1);
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    resp_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("rstmid_resp_valid", {63'd0, m_resp_valid}, 64'd0);
    chk("rstmid_cnt", {32'd0, m_cnt_corr, m_cnt_unc}, 64'd0);
    chk("sb_drained", sb.size(), 64'd0);
    @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
